cache_line_mem_ctrl: RTL
========================

// Module: cache_line_mem_ctrl
// PURPOSE
//  Line-transfer engine directly downstream of the cache: moves whole cache lines between the
//  cache and the 32-bit memory bus. Write-back: splits a dirty victim line into word beats.
//  Refill: assembles word reads into a line for the cache's load path.
//  Cache side: save_data -> wb_req, save_ready <- wb_done, write_load_data <- fill_line.
// PARAMETERS
//  LINE_BYTES  16  bytes per cache line; multiple of 4, >= 8; WORDS = LINE_BYTES/4
//  ADDR_W      32  address width
//  DATA_W      32  memory bus word width; fixed at 32
// PORTS
//  clk        in   1             clock
//  rst        in   1             synchronous reset, active-high
//  wb_req     in   1             write back wb_line to wb_addr (level)
//  wb_addr    in   ADDR_W        victim line address; low log2(LINE_BYTES) bits ignored
//  wb_line    in   LINE_BYTES*8  victim line data; word i = wb_line[32*i +: 32]
//  wb_done    out  1             1-cycle pulse: all write beats accepted
//  fill_req   in   1             refill line from fill_addr (level)
//  fill_addr  in   ADDR_W        refill line address; low bits ignored
//  fill_line  out  LINE_BYTES*8  assembled refill line
//  fill_done  out  1             1-cycle pulse: fill_line valid
//  busy       out  1             high in every state except IDLE
//  mem_req    out  1             memory beat request
//  mem_we     out  1             1 = write beat, 0 = read beat
//  mem_addr   out  ADDR_W        word address of current beat
//  mem_wdata  out  32            write data of current beat
//  mem_ready  in   1             beat completes on a rising edge where mem_req & mem_ready
//  mem_rdata  in   32            read data; valid in the completing cycle
// BEHAVIOUR
//  - Reset: state IDLE, beat counter 0. wb_done, fill_done, busy, mem_req, mem_we = 0.
//    mem_addr, mem_wdata, fill_line = 0. A reset mid-transfer abandons the beat.
//  - FSM: IDLE -> WB | FILL; WB -> WB_DONE; FILL -> FILL_DONE; *_DONE -> IDLE.
//  - IDLE: requests are sampled every cycle. wb_req has priority over fill_req, because the
//    victim must reach memory before it is overwritten. On acceptance, the line base
//    (addr & ~(LINE_BYTES-1)) is latched; for write-back, wb_line is latched as well.
//    Inputs may change after acceptance.
//  - WB/FILL: mem_req = 1, mem_we = (state == WB), mem_addr = base + 4*cnt,
//    mem_wdata = latched word[cnt].
//    mem_addr, mem_we and mem_wdata are held stable until the beat completes.
//    On completion: FILL writes mem_rdata into fill_line[32*cnt +: 32]; cnt increments.
//    After beat WORDS-1 completes, cnt returns to 0 and the FSM moves to *_DONE.
//  - Beat order: ascending addresses, little-endian word placement.
//    mem_ready is ignored while mem_req = 0.
//  - WB_DONE/FILL_DONE: the matching done output is high for exactly this one cycle;
//    mem_req = 0; next state is IDLE.
//  - Latency: with mem_ready tied high, done is high in cycle WORDS+1 after the acceptance edge.
//    Each mem_ready wait cycle adds one cycle.
//  - fill_line changes only in FILL. It holds its value after fill_done until the next FILL beat.
//  - A request still high in the IDLE cycle after *_DONE starts a new transfer.
//    The minimum gap between transfers is one IDLE cycle. Requesters drop req on done.
//  - Both requests high: WB runs first, then FILL (fill_req still high) after one IDLE cycle.
//  - Beat counter width: max(1, $clog2(WORDS)). No address carry handling beyond ADDR_W wrap.
// TESTING
//  1 fill_addr=0x1234, ready tied high, rdata 0x11111111..0x44444444
//    -> reads at 0x1230, 0x1234, 0x1238, 0x123C
//    -> fill_line = 128'h44444444_33333333_22222222_11111111; one fill_done pulse in cycle 5.
//  2 wb_addr=0x2000, wb_line = DDDD.._CCCC.._BBBB.._AAAA.., mem_ready every 3rd cycle
//    -> writes AAAA@0x2000 .. DDDD@0x200C
//    -> addr/wdata stable while stalled; wb_done after the 4th accept.
//  3 wb_req and fill_req rise together
//    -> 4 write beats, wb_done, 1 IDLE cycle, then 4 read beats and fill_done; never interleaved.
//  4 rst pulsed after 2 completed fill beats
//    -> next cycle mem_req=0, busy=0, fill_line=0, no fill_done
//    -> new fill restarts at the line base.
//  5 fill_req held high through fill_done -> second fill starts after exactly one IDLE cycle.
//  6 mem_ready high while idle -> no beat, no state change, no done pulse.

Source files
------------

// File: rtl/cache_line_mem_ctrl_if.sv
// rtl/cache_line_mem_ctrl_if.sv - cache-side request/response and memory beat bus bundle
// master = line-transfer engine, slave = cache plus memory environment.
interface cache_line_mem_ctrl_if #(
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
);
  logic                    wb_req;
  logic [ADDR_W-1:0]       wb_addr;
  logic [LINE_BYTES*8-1:0] wb_line;
  logic                    wb_done;
  logic                    fill_req;
  logic [ADDR_W-1:0]       fill_addr;
  logic [LINE_BYTES*8-1:0] fill_line;
  logic                    fill_done;
  logic                    busy;
  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic                    mem_ready;
  logic [DATA_W-1:0]       mem_rdata;

  modport master (
    input  wb_req, wb_addr, wb_line, fill_req, fill_addr, mem_ready, mem_rdata,
    output wb_done, fill_line, fill_done, busy, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output wb_req, wb_addr, wb_line, fill_req, fill_addr, mem_ready, mem_rdata,
    input  wb_done, fill_line, fill_done, busy, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_line_mem_ctrl.sv
// rtl/cache_line_mem_ctrl.sv - cache line write-back/refill engine over a 32-bit word bus
// Splits victim lines into write beats and assembles read beats into refill lines.
module cache_line_mem_ctrl #(
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_line_mem_ctrl_if.master bus
);
  localparam int WORDS  = LINE_BYTES / 4;
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int CNT_W  = (WORDS > 2) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(WORDS - 1);
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(LINE_BYTES - 1);

  typedef enum logic [2:0] {IDLE, WB, FILL, WB_DONE, FILL_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [LINE_W-1:0]   fill_line_q, fill_line_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic                wb_done_q, wb_done_d;
  logic                fill_done_q, fill_done_d;
  logic                busy_q, busy_d;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    fill_line_d = fill_line_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    wb_done_d   = 1'b0;
    fill_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        // Write-back wins so the victim reaches memory before its slot is refilled.
        if (bus.wb_req) begin
          state_d     = WB;
          cnt_d       = '0;
          line_d      = bus.wb_line;
          mem_addr_d  = bus.wb_addr & ~OFS_MASK;
          mem_wdata_d = bus.wb_line[DATA_W-1:0];
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
        end else if (bus.fill_req) begin
          state_d    = FILL;
          cnt_d      = '0;
          mem_addr_d = bus.fill_addr & ~OFS_MASK;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
        end
      end
      WB, FILL: begin
        if (bus.mem_ready) begin
          if (state_q == FILL) begin
            fill_line_d[int'(cnt_q) * DATA_W +: DATA_W] = bus.mem_rdata;
          end
          if (cnt_q == LAST) begin
            cnt_d       = '0;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            state_d     = (state_q == WB) ? WB_DONE : FILL_DONE;
            wb_done_d   = (state_q == WB);
            fill_done_d = (state_q == FILL);
          end else begin
            cnt_d       = cnt_inc;
            mem_addr_d  = mem_addr_q + ADDR_W'(4);
            mem_wdata_d = line_q[int'(cnt_inc) * DATA_W +: DATA_W];
          end
        end
      end
      WB_DONE, FILL_DONE: state_d = IDLE;
      default:            state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      line_q      <= '0;
      fill_line_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      wb_done_q   <= 1'b0;
      fill_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      fill_line_q <= fill_line_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      wb_done_q   <= wb_done_d;
      fill_done_q <= fill_done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.wb_done   = wb_done_q;
  assign bus.fill_done = fill_done_q;
  assign bus.fill_line = fill_line_q;
  assign bus.busy      = busy_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule
